// File: rtl/bb_mem_ctrl.sv
// Data-memory controller behind bb_core: services READ/WRITE actions on a local
// word-addressed RAM with a fixed number of wait states and a sticky error register.
module bb_mem_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_err_clr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  output logic                  o_wr_done,
  output logic                  o_busy,
  output logic [2:0]            o_err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("bb_mem_ctrl: WAIT_CYCLES must be in 0..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS >= DATA_WIDTH) begin : g_bad_addr
      $error("bb_mem_ctrl: ADDR_BITS must be in 1..DATA_WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic                   op_write_reg;
  logic                   legal_reg;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]  wdata_reg;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic                   rd_valid_reg;
  logic                   wr_done_reg;
  logic [2:0]             err_reg;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_rdata_reg;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic                   mem_we;

  logic [1:0]             opcode;
  logic                   is_access;
  logic                   addr_legal;
  logic [2:0]             err_set;
  logic                   unused_action_bits;

  assign opcode             = i_action[1:0];
  assign is_access          = (opcode == OP_READ) || (opcode == OP_WRITE);
  assign addr_legal         = ((i_addr >> ADDR_BITS) == '0);
  assign unused_action_bits = ^i_action[DATA_WIDTH-1:2];

  // Errors raised this cycle; busy drops take priority over decoding the opcode.
  always_comb begin
    err_set = 3'b000;
    if (state_reg == S_IDLE) begin
      if (is_access && !addr_legal) err_set[0] = 1'b1;
      if (opcode == OP_RSVD)        err_set[2] = 1'b1;
    end else if (opcode != OP_NOP) begin
      err_set[1] = 1'b1;
    end
  end

  // The read port follows the incoming address while idle so that, even with no
  // wait states, the word is already registered when DONE is reached.
  assign rd_addr = (state_reg == S_IDLE) ? i_addr[ADDR_BITS-1:0] : addr_reg;
  assign mem_we  = rst_n && (state_reg == S_DONE) && op_write_reg && legal_reg;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_reg] <= wdata_reg;
    end
    mem_rdata_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      op_write_reg <= 1'b0;
      legal_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      rd_valid_reg <= 1'b0;
      wr_done_reg  <= 1'b0;
      err_reg      <= 3'b000;
    end else begin
      rd_valid_reg <= 1'b0;
      wr_done_reg  <= 1'b0;
      err_reg      <= (i_err_clr ? 3'b000 : err_reg) | err_set;
      case (state_reg)
        S_IDLE: begin
          if (is_access) begin
            op_write_reg <= (opcode == OP_WRITE);
            legal_reg    <= addr_legal;
            addr_reg     <= i_addr[ADDR_BITS-1:0];
            wdata_reg    <= i_data;
            cnt_reg      <= WAIT_LOAD;
            state_reg    <= (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          if (op_write_reg) begin
            wr_done_reg <= 1'b1;
          end else begin
            rd_valid_reg <= 1'b1;
            data_reg     <= legal_reg ? mem_rdata_reg : '0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = (state_reg != S_IDLE);
  assign o_data     = data_reg;
  assign o_rd_valid = rd_valid_reg;
  assign o_wr_done  = wr_done_reg;
  assign o_err      = err_reg;

endmodule

// File: tb/tb_bb_mem_ctrl.sv
// Bench for bb_mem_ctrl: directed and random accesses against a simple
// array/arithmetic model, with a second instance running zero wait states.
module tb_bb_mem_ctrl;
  localparam int DW = 16;
  localparam int AB = 8;
  localparam int W  = 2;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_n0;
  logic [DW-1:0] action, addr, wdata, action0, addr0, wdata0;
  logic          err_clr, err_clr0;
  logic [DW-1:0] data, data0;
  logic          rd_valid, wr_done, busy, rd_valid0, wr_done0, busy0;
  logic [2:0]    err, err0;

  bb_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_action(action), .i_addr(addr), .i_data(wdata),
    .i_err_clr(err_clr), .o_data(data), .o_rd_valid(rd_valid), .o_wr_done(wr_done),
    .o_busy(busy), .o_err(err)
  );

  bb_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .i_action(action0), .i_addr(addr0), .i_data(wdata0),
    .i_err_clr(err_clr0), .o_data(data0), .o_rd_valid(rd_valid0), .o_wr_done(wr_done0),
    .o_busy(busy0), .o_err(err0)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [256];
  bit            written [256];
  logic [DW-1:0] exp_data;
  logic [2:0]    exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on the wait-state instance and follow it to completion.
  // Optionally present a READ at cycle drop_at of the busy window.
  task automatic do_access(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] d,
                           input int drop_at, input logic drop_clr);
    logic lg;
    lg = ((a >> AB) == 0);
    action = {14'($urandom), op};
    addr   = a;
    wdata  = d;
    if (!lg) exp_err |= 3'b001;
    if (op == WR && lg) begin
      ref_mem[a[7:0]] = d;
      written[a[7:0]] = 1'b1;
    end
    step();
    action = '0;
    addr   = 16'($urandom);
    wdata  = 16'($urandom);
    for (int k = 1; k <= W + 1; k++) begin
      chk($sformatf("busy_k%0d", k), busy, 1'b1);
      chk($sformatf("rdv_k%0d", k), rd_valid, 1'b0);
      chk($sformatf("wrd_k%0d", k), wr_done, 1'b0);
      chk($sformatf("hold_k%0d", k), data, exp_data);
      if (k == drop_at) begin
        action  = 16'h0001;
        err_clr = drop_clr;
      end
      step();
      if (k == drop_at) begin
        action  = '0;
        err_clr = 1'b0;
        exp_err = (drop_clr ? 3'b000 : exp_err) | 3'b010;
      end
    end
    if (op == RD) exp_data = lg ? ref_mem[a[7:0]] : '0;
    chk("done_busy", busy, 1'b0);
    chk("done_rdv", rd_valid, (op == RD));
    chk("done_wrd", wr_done, (op == WR));
    chk("done_data", data, exp_data);
    chk("done_err", err, exp_err);
    $display("access op=%0d addr=%04h wdata=%04h -> data=%04h err=%03b", op, a, d, data, err);
  endtask

  initial begin
    rst_n = 1'b0; rst_n0 = 1'b0;
    action = '0; addr = '0; wdata = '0; err_clr = 1'b0;
    action0 = '0; addr0 = '0; wdata0 = '0; err_clr0 = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data, 16'h0000);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_wrd", wr_done, 1'b0);
    chk("rst_err", err, 3'b000);
    chk("rst0_busy", busy0, 1'b0);
    rst_n = 1'b1; rst_n0 = 1'b1;
    exp_data = '0;
    exp_err  = 3'b000;
    step();

    // Write then read back-to-back, accepted in the completion cycle.
    do_access(WR, 16'h0003, 16'h00A5, 0, 1'b0);
    do_access(RD, 16'h0003, 16'h0000, 0, 1'b0);
    step();
    chk("read_hold", data, 16'h00A5);

    // Out-of-range read and write.
    do_access(RD, 16'h0103, 16'h0000, 0, 1'b0);
    do_access(WR, 16'h0103, 16'h1111, 0, 1'b0);
    do_access(RD, 16'h0003, 16'h0000, 0, 1'b0);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err = 3'b000;
    chk("clr_err", err, exp_err);

    // READ presented while a WRITE is in flight.
    do_access(WR, 16'h0010, 16'h2222, 2, 1'b0);
    step();
    chk("drop_no_rdv", rd_valid, 1'b0);
    chk("drop_err", err, 3'b010);

    // Reserved opcode while idle.
    action = 16'hFF03;
    step();
    action = '0;
    exp_err |= 3'b100;
    chk("rsvd_err", err, exp_err);
    chk("rsvd_idle", busy, 1'b0);

    // Clear coincident with a new drop: the drop wins.
    do_access(WR, 16'h0020, 16'h3333, 1, 1'b1);
    chk("clr_vs_drop", err, 3'b010);

    // Zero wait states: completions two cycles apart.
    action0 = {14'h0, WR}; addr0 = 16'h0007; wdata0 = 16'h5A5A;
    step();
    action0 = '0;
    chk("z_busy_w", busy0, 1'b1);
    chk("z_wrd_early", wr_done0, 1'b0);
    step();
    chk("z_wrd", wr_done0, 1'b1);
    chk("z_idle", busy0, 1'b0);
    action0 = {14'h0, RD}; addr0 = 16'h0007;
    step();
    action0 = '0;
    chk("z_busy_r", busy0, 1'b1);
    chk("z_rdv_early", rd_valid0, 1'b0);
    step();
    chk("z_rdv", rd_valid0, 1'b1);
    chk("z_data", data0, 16'h5A5A);
    $display("zero-wait write/read addr=0007 -> data=%04h", data0);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]    op;
      logic [DW-1:0] a;
      int            drop;
      op = ($urandom_range(0, 1) == 0) ? RD : WR;
      if ($urandom_range(0, 4) == 0)
        a = 16'({$urandom_range(1, 255), 8'($urandom)});
      else
        a = 16'($urandom_range(0, 255));
      if (op == RD && ((a >> AB) == 0) && !written[a[7:0]]) op = WR;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      do_access(op, a, 16'($urandom), drop, 1'b0);
    end

    // Reset in the middle of a WRITE abandons it.
    action = {14'h0, WR}; addr = 16'h0009; wdata = 16'hBEEF;
    step();
    action = '0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", data, 16'h0000);
    chk("mid_rst_err", err, 3'b000);
    chk("mid_rst_wrd", wr_done, 1'b0);
    rst_n = 1'b1;
    exp_data = '0;
    exp_err  = 3'b000;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("no_wrd_%0d", k), wr_done, 1'b0);
    end
    do_access(WR, 16'h0009, 16'h0000, 0, 1'b0);
    do_access(RD, 16'h0009, 16'h0000, 0, 1'b0);
    chk("abandon_data", data, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
